// File: rtl/dpll_lock_detect.sv
// dpll_lock_detect
// Lock detector for the DPLL, clocked by the divided feedback clock.
// Each cycle the signed TDC phase error and the change in the DCO control
// word are checked against a phase/frequency window. A run-length state
// machine with hysteresis turns that into a lock flag. Alongside it the
// block keeps a saturating slip counter and the peak |terr| seen since
// lock was last declared.
module dpll_lock_detect #(
  parameter int WIDTH      = 4,
  parameter int DWIDTH     = 13,
  parameter int TOL        = 1,
  parameter int DTOL       = 2,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] terr,
  input  logic [DWIDTH-1:0]       dctrl,
  output logic                    lock,
  output logic [1:0]              state,
  output logic [CNT_W-1:0]        run_cnt,
  output logic [7:0]              slip_count,
  output logic [WIDTH-1:0]        terr_peak
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    SLIP     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  LOCK_TGT   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  UNLOCK_TGT = CNT_W'(UNLOCK_CNT);
  localparam logic [WIDTH:0]    TOL_W      = (WIDTH+1)'(TOL);
  localparam logic [DWIDTH:0]   DTOL_W     = (DWIDTH+1)'(DTOL);
  localparam logic [WIDTH:0]    PEAK_MAX   = {1'b0, {WIDTH{1'b1}}};

  state_t                  cur;
  state_t                  nxt;

  // previous control word, and whether it holds a real sample yet
  logic [DWIDTH-1:0]       dctrl_prev;
  logic                    prev_valid;

  // window evaluation
  logic signed [WIDTH:0]   terr_ext;
  logic [WIDTH:0]          terr_mag;
  logic [WIDTH-1:0]        terr_mag_sat;
  logic signed [DWIDTH:0]  dctrl_diff;
  logic [DWIDTH:0]         dctrl_mag;
  logic                    in_win;

  // next-state datapath
  logic [CNT_W-1:0]        cnt_inc;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    slip_event;
  logic                    peak_load;
  logic                    peak_track;
  logic [WIDTH-1:0]        peak_nxt;
  logic [7:0]              slip_nxt;
  logic                    lock_nxt;

  assign state = cur;

  // Phase and frequency window check; magnitudes carry one extra bit so the
  // most negative terr and the widest dctrl step cannot wrap.
  always_comb begin
    terr_ext   = {terr[WIDTH-1], terr};
    terr_mag   = terr_ext[WIDTH] ? $unsigned(-terr_ext) : $unsigned(terr_ext);
    dctrl_diff = $signed({1'b0, dctrl}) - $signed({1'b0, dctrl_prev});
    dctrl_mag  = dctrl_diff[DWIDTH] ? $unsigned(-dctrl_diff) : $unsigned(dctrl_diff);
    in_win     = prev_valid && (terr_mag <= TOL_W) && (dctrl_mag <= DTOL_W);
    terr_mag_sat = (terr_mag > PEAK_MAX) ? PEAK_MAX[WIDTH-1:0] : terr_mag[WIDTH-1:0];
    cnt_inc    = run_cnt + 1'b1;
  end

  // Next-state and run-counter logic with lock/unlock hysteresis.
  always_comb begin
    nxt        = cur;
    cnt_nxt    = run_cnt;
    slip_event = 1'b0;
    peak_load  = 1'b0;
    unique case (cur)
      UNLOCKED: begin
        cnt_nxt = '0;
        if (in_win) begin
          if (LOCK_CNT == 1) begin
            nxt       = LOCKED;
            peak_load = 1'b1;
          end else begin
            nxt     = ACQUIRE;
            cnt_nxt = CNT_W'(1);
          end
        end
      end
      ACQUIRE: begin
        if (in_win) begin
          if (cnt_inc == LOCK_TGT) begin
            nxt       = LOCKED;
            cnt_nxt   = '0;
            peak_load = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          nxt     = UNLOCKED;
          cnt_nxt = '0;
        end
      end
      LOCKED: begin
        cnt_nxt = '0;
        if (!in_win) begin
          if (UNLOCK_CNT == 1) begin
            nxt        = UNLOCKED;
            slip_event = 1'b1;
          end else begin
            nxt     = SLIP;
            cnt_nxt = CNT_W'(1);
          end
        end
      end
      SLIP: begin
        if (!in_win) begin
          if (cnt_inc == UNLOCK_TGT) begin
            nxt        = UNLOCKED;
            cnt_nxt    = '0;
            slip_event = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          nxt     = LOCKED;
          cnt_nxt = '0;
        end
      end
      default: begin
        nxt     = UNLOCKED;
        cnt_nxt = '0;
      end
    endcase
  end

  // Output-side next values: peak tracking, slip statistics, lock flag.
  always_comb begin
    peak_track = (cur == LOCKED) || (cur == SLIP);
    peak_nxt   = terr_peak;
    if (peak_load) begin
      peak_nxt = terr_mag_sat;
    end else if (peak_track && (terr_mag_sat > terr_peak)) begin
      peak_nxt = terr_mag_sat;
    end
    slip_nxt = slip_count;
    if (slip_event && (slip_count != 8'hFF)) begin
      slip_nxt = slip_count + 8'd1;
    end
    lock_nxt = (nxt == LOCKED) || (nxt == SLIP);
  end

  // State register and all registered outputs; lock is taken from the
  // next-state value so it always agrees with state in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= UNLOCKED;
      run_cnt    <= '0;
      lock       <= 1'b0;
      slip_count <= '0;
      terr_peak  <= '0;
      dctrl_prev <= '0;
      prev_valid <= 1'b0;
    end else begin
      cur        <= nxt;
      run_cnt    <= cnt_nxt;
      lock       <= lock_nxt;
      slip_count <= slip_nxt;
      terr_peak  <= peak_nxt;
      dctrl_prev <= dctrl;
      prev_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dpll_lock_detect.sv
// Testbench for dpll_lock_detect: default-parameter instance (a) and a
// LOCK_CNT=1/UNLOCK_CNT=1 instance (b) share stimulus; a behavioural model
// pushes expected outputs into per-instance queues every cycle.
module tb_dpll_lock_detect;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic signed [3:0] terr = '0;
  logic [12:0]       dctrl = '0;

  logic        lock_a, lock_b;
  logic [1:0]  state_a, state_b;
  logic [7:0]  run_a, run_b;
  logic [7:0]  slip_a, slip_b;
  logic [3:0]  peak_a, peak_b;
  logic [22:0] obs_a, obs_b;

  assign obs_a = {lock_a, state_a, run_a, slip_a, peak_a};
  assign obs_b = {lock_b, state_b, run_b, slip_b, peak_b};

  always #5 clk = ~clk;

  dpll_lock_detect #(.WIDTH(4), .DWIDTH(13), .TOL(1), .DTOL(2),
                     .LOCK_CNT(64), .UNLOCK_CNT(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .terr(terr), .dctrl(dctrl),
    .lock(lock_a), .state(state_a), .run_cnt(run_a),
    .slip_count(slip_a), .terr_peak(peak_a));

  dpll_lock_detect #(.WIDTH(4), .DWIDTH(13), .TOL(1), .DTOL(2),
                     .LOCK_CNT(1), .UNLOCK_CNT(1), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .terr(terr), .dctrl(dctrl),
    .lock(lock_b), .state(state_b), .run_cnt(run_b),
    .slip_count(slip_b), .terr_peak(peak_b));

  typedef struct {
    int st;
    int cnt;
    int slip;
    int peak;
    int prev;
    int pv;
  } mdl_t;

  mdl_t ma, mb;
  logic [22:0] qa[$];
  logic [22:0] qb[$];
  logic [22:0] ea, eb;
  int n_checks = 0;
  int n_fail = 0;

  function automatic mdl_t model(input mdl_t m, input int t, input int d,
                                 input int lc, input int uc, input bit r);
    mdl_t n;
    int at, ad;
    bit inw;
    n = m;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    at  = (t < 0) ? -t : t;
    ad  = d - m.prev;
    if (ad < 0) ad = -ad;
    inw = (m.pv != 0) && (at <= 1) && (ad <= 2);
    if (m.st >= 2 && at > n.peak) n.peak = (at > 15) ? 15 : at;
    case (m.st)
      0: begin
        n.cnt = 0;
        if (inw) begin
          if (lc == 1) begin n.st = 2; n.peak = at; end
          else begin n.st = 1; n.cnt = 1; end
        end
      end
      1: begin
        if (!inw) begin n.st = 0; n.cnt = 0; end
        else if (m.cnt + 1 == lc) begin n.st = 2; n.cnt = 0; n.peak = at; end
        else n.cnt = m.cnt + 1;
      end
      2: begin
        n.cnt = 0;
        if (!inw) begin
          if (uc == 1) begin n.st = 0; n.slip = (m.slip < 255) ? m.slip + 1 : 255; end
          else begin n.st = 3; n.cnt = 1; end
        end
      end
      default: begin
        if (inw) begin n.st = 2; n.cnt = 0; end
        else if (m.cnt + 1 == uc) begin
          n.st = 0; n.cnt = 0; n.slip = (m.slip < 255) ? m.slip + 1 : 255;
        end else n.cnt = m.cnt + 1;
      end
    endcase
    n.prev = d;
    n.pv   = 1;
    return n;
  endfunction

  function automatic logic [22:0] pack(input mdl_t m);
    logic [1:0] s;
    logic [7:0] c, sl;
    logic [3:0] p;
    s = 2'(m.st); c = 8'(m.cnt); sl = 8'(m.slip); p = 4'(m.peak);
    return {(m.st >= 2), s, c, sl, p};
  endfunction

  // Drive one cycle of stimulus and queue the expected outputs for it.
  task automatic step(input int t, input int d, input bit r);
    reset = r;
    terr  = 4'(t);
    dctrl = 13'(d);
    ma = model(ma, t, d, 64, 4, r);
    mb = model(mb, t, d, 1, 1, r);
    qa.push_back(pack(ma));
    qb.push_back(pack(mb));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1'b1);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_fail++; $display("FAIL reset_a got=%h exp=%h", obs_a, ea); end
      if (obs_b !== eb) begin n_fail++; $display("FAIL reset_b got=%h exp=%h", obs_b, eb); end
    end
    n_checks++;
    if (obs_a !== 23'h0) begin n_fail++; $display("FAIL reset_zero got=%h exp=0", obs_a); end
  endtask

  task automatic test_acquire_lock();
    for (int i = 1; i <= 65; i++) begin
      step(0, 4096, 1'b0);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_fail++; $display("FAIL acquire_a cyc=%0d got=%h exp=%h", i, obs_a, ea); end
      if (obs_b !== eb) begin n_fail++; $display("FAIL acquire_b cyc=%0d got=%h exp=%h", i, obs_b, eb); end
      if (i == 64) begin
        n_checks++;
        if (run_a !== 8'd63 || state_a !== 2'd1 || lock_a !== 1'b0) begin
          n_fail++; $display("FAIL acquire_63 run=%0d state=%0d lock=%b exp 63/1/0", run_a, state_a, lock_a);
        end
      end
      if (i == 65) begin
        n_checks++;
        if (lock_a !== 1'b1 || state_a !== 2'd2 || slip_a !== 8'd0) begin
          n_fail++; $display("FAIL lock_rise lock=%b state=%0d slip=%0d exp 1/2/0", lock_a, state_a, slip_a);
        end
      end
    end
  endtask

  task automatic test_slip_recover();
    for (int i = 1; i <= 4; i++) begin
      step((i <= 3) ? 3 : 0, 4096, 1'b0);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 3;
      if (obs_a !== ea) begin n_fail++; $display("FAIL slip_rec_a cyc=%0d got=%h exp=%h", i, obs_a, ea); end
      if (obs_b !== eb) begin n_fail++; $display("FAIL slip_rec_b cyc=%0d got=%h exp=%h", i, obs_b, eb); end
      if (lock_a !== 1'b1 || peak_a !== 4'd3) begin
        n_fail++; $display("FAIL slip_hold cyc=%0d lock=%b peak=%0d exp 1/3", i, lock_a, peak_a);
      end
    end
  endtask

  task automatic test_drop(input int exp_slip);
    for (int i = 1; i <= 4; i++) begin
      step(-8, 4096, 1'b0);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_fail++; $display("FAIL drop_a cyc=%0d got=%h exp=%h", i, obs_a, ea); end
      if (obs_b !== eb) begin n_fail++; $display("FAIL drop_b cyc=%0d got=%h exp=%h", i, obs_b, eb); end
    end
    n_checks++;
    if (lock_a !== 1'b0 || state_a !== 2'd0 || slip_a !== 8'(exp_slip) || peak_a !== 4'd8) begin
      n_fail++; $display("FAIL drop_final lock=%b state=%0d slip=%0d peak=%0d exp 0/0/%0d/8",
                         lock_a, state_a, slip_a, peak_a, exp_slip);
    end
  endtask

  task automatic test_acquire_break();
    for (int i = 1; i <= 40; i++) begin
      step(0, 4096, 1'b0);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_fail++; $display("FAIL brk_pre_a cyc=%0d got=%h exp=%h", i, obs_a, ea); end
      if (obs_b !== eb) begin n_fail++; $display("FAIL brk_pre_b cyc=%0d got=%h exp=%h", i, obs_b, eb); end
    end
    n_checks++;
    if (run_a !== 8'd40 || state_a !== 2'd1) begin
      n_fail++; $display("FAIL brk_run40 run=%0d state=%0d exp 40/1", run_a, state_a);
    end
    step(0, 4099, 1'b0);
    ea = qa.pop_front(); eb = qb.pop_front();
    n_checks += 3;
    if (obs_a !== ea) begin n_fail++; $display("FAIL brk_step_a got=%h exp=%h", obs_a, ea); end
    if (obs_b !== eb) begin n_fail++; $display("FAIL brk_step_b got=%h exp=%h", obs_b, eb); end
    if (state_a !== 2'd0 || run_a !== 8'd0) begin
      n_fail++; $display("FAIL brk_unlock state=%0d run=%0d exp 0/0", state_a, run_a);
    end
    for (int i = 1; i <= 64; i++) begin
      step(0, 4099, 1'b0);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_fail++; $display("FAIL brk_relock_a cyc=%0d got=%h exp=%h", i, obs_a, ea); end
      if (obs_b !== eb) begin n_fail++; $display("FAIL brk_relock_b cyc=%0d got=%h exp=%h", i, obs_b, eb); end
      if (i == 63 || i == 64) begin
        n_checks++;
        if (lock_a !== (i == 64)) begin
          n_fail++; $display("FAIL brk_relock_edge cyc=%0d lock=%b exp=%b", i, lock_a, (i == 64));
        end
      end
    end
  endtask

  task automatic test_reset_in_slip();
    // Repeated drop/relock cycles to bring slip_count to 5, then enter SLIP.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 68; i++) begin
        step((i < 4) ? -8 : 0, 4099, 1'b0);
        ea = qa.pop_front(); eb = qb.pop_front();
        n_checks += 2;
        if (obs_a !== ea) begin n_fail++; $display("FAIL reslip_a k=%0d cyc=%0d got=%h exp=%h", k, i, obs_a, ea); end
        if (obs_b !== eb) begin n_fail++; $display("FAIL reslip_b k=%0d cyc=%0d got=%h exp=%h", k, i, obs_b, eb); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(5, 4099, 1'b0);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_fail++; $display("FAIL slip_in_a cyc=%0d got=%h exp=%h", i, obs_a, ea); end
      if (obs_b !== eb) begin n_fail++; $display("FAIL slip_in_b cyc=%0d got=%h exp=%h", i, obs_b, eb); end
    end
    n_checks++;
    if (state_a !== 2'd3 || slip_a !== 8'd5 || lock_a !== 1'b1) begin
      n_fail++; $display("FAIL slip5 state=%0d slip=%0d lock=%b exp 3/5/1", state_a, slip_a, lock_a);
    end
    step(5, 4099, 1'b1);
    ea = qa.pop_front(); eb = qb.pop_front();
    n_checks += 3;
    if (obs_a !== ea) begin n_fail++; $display("FAIL slip_rst_a got=%h exp=%h", obs_a, ea); end
    if (obs_b !== eb) begin n_fail++; $display("FAIL slip_rst_b got=%h exp=%h", obs_b, eb); end
    if (obs_a !== 23'h0) begin n_fail++; $display("FAIL slip_rst_zero got=%h exp=0", obs_a); end
  endtask

  task automatic test_corner_saturate();
    step(0, 100, 1'b0);
    ea = qa.pop_front(); eb = qb.pop_front();
    n_checks += 2;
    if (obs_a !== ea) begin n_fail++; $display("FAIL corner_warm_a got=%h exp=%h", obs_a, ea); end
    if (obs_b !== eb) begin n_fail++; $display("FAIL corner_warm_b got=%h exp=%h", obs_b, eb); end
    for (int i = 0; i < 600; i++) begin
      step((i % 2 == 0) ? 0 : 3, 100, 1'b0);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_fail++; $display("FAIL corner_a cyc=%0d got=%h exp=%h", i, obs_a, ea); end
      if (obs_b !== eb) begin n_fail++; $display("FAIL corner_b cyc=%0d got=%h exp=%h", i, obs_b, eb); end
      if (i < 2) begin
        n_checks++;
        if (lock_b !== (i == 0)) begin
          n_fail++; $display("FAIL corner_toggle cyc=%0d lock=%b exp=%b", i, lock_b, (i == 0));
        end
      end
    end
    n_checks++;
    if (slip_b !== 8'd255) begin n_fail++; $display("FAIL slip_sat got=%0d exp=255", slip_b); end
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    test_reset();
    test_acquire_lock();
    test_slip_recover();
    test_drop(1);
    test_acquire_break();
    test_reset_in_slip();
    test_corner_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
